// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: skid FSM states and the bubble control encoding.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package pipe_pkg;

    typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_t;

    // All-zero control word is a bubble; replicated to CTRL_W at the use site.
    localparam logic BUBBLE_CTRL = 1'b0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry plus occupancy FSM; owns out_valid and a registered in_ready for the stage.
// Latency: 1 cycle from input transfer to out_valid; a skidded word moves to main when out_ready rises.
// Backpressure: in_ready is a flop (low only while the skid entry is full), so no comb path from out_ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              out_valid,
    output logic              load_in,
    output logic              load_skid,
    output logic [CTRL_W-1:0] skid_ctrl,
    output logic [DATA_W-1:0] skid_data
);

    pipe_state_t state;
    logic        in_xfer;

    assign in_xfer   = in_valid & in_ready;
    // Main register takes the input when empty or when its current word leaves this cycle.
    assign load_in   = !flush & in_xfer & ((state == PS_EMPTY) | out_ready);
    assign load_skid = !flush & (state == PS_FULL) & out_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= PS_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= PS_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (in_xfer) begin
                        state     <= PS_ONE;
                        out_valid <= 1'b1;
                    end
                end
                PS_ONE: begin
                    if (in_xfer && !out_ready) begin
                        state     <= PS_FULL;
                        in_ready  <= 1'b0;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (!in_xfer && out_ready) begin
                        state     <= PS_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                PS_FULL: begin
                    if (out_ready) begin
                        state    <= PS_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= PS_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush-to-bubble and saturating stall counter; PIPE_SKID_EN adds a skid entry.
// Latency: 1 cycle from input transfer to out_valid in both builds.
// Backpressure: comb in_ready = !out_valid | out_ready by default; registered in_ready with PIPE_SKID_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic load_in;

`ifdef PIPE_SKID_EN
    logic              load_skid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .load_in   (load_in),
        .load_skid (load_skid),
        .skid_ctrl (skid_ctrl),
        .skid_data (skid_data)
    );
`else
    assign in_ready = !out_valid | out_ready;
    assign load_in  = !flush & in_ready & in_valid;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
        end
    end
`endif

    // Flush clears control only; payload is left as-is since a bubble ignores it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_ctrl <= '0;
            out_data <= '0;
        end else if (flush) begin
            out_ctrl <= {CTRL_W{BUBBLE_CTRL}};
`ifdef PIPE_SKID_EN
        end else if (load_skid) begin
            out_ctrl <= skid_ctrl;
            out_data <= skid_data;
`endif
        end else if (load_in) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (CNT_W=4); expectations adapt to PIPE_SKID_EN where in_ready timing differs.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
`ifdef PIPE_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic              CLK;
    logic              nRST;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              stall_clr;
    logic [CNT_W-1:0]  stall_cnt;

    int   n_tests;
    int   n_fail;
    logic rdy_b;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_clr (stall_clr),
        .stall_cnt (stall_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        nRST      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        stall_clr = 1'b0;

        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl",  32'(out_ctrl),  32'd0);
        chk("rst_data",  out_data,       32'd0);
        chk("rst_cnt",   32'(stall_cnt), 32'd0);
        nRST = 1'b1;
        step();
        chk("rdy_after_rst", 32'(in_ready), 32'd1);

        // Streaming 1,2,3 with no backpressure
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_ctrl = 8'(i);
            in_data = 32'(i);
            chk("stream_rdy", 32'(in_ready), 32'd1);
            step();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data",  out_data,       32'(i));
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain", 32'(out_valid), 32'd0);

        // Backpressure: hold 0xA for 3 stall cycles, then offer 0xB
        in_valid  = 1'b1;
        in_ctrl   = 8'h0A;
        in_data   = 32'hA;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("bp_load", 32'(out_valid), 32'd1);
        repeat (3) step();
        chk("bp_hold_data", out_data,       32'hA);
        chk("bp_hold_ctrl", 32'(out_ctrl),  32'h0A);
        chk("bp_cnt3",      32'(stall_cnt), 32'd3);
        in_valid = 1'b1;
        in_ctrl  = 8'h0B;
        in_data  = 32'hB;
        rdy_b    = in_ready;
        chk("bp_rdy_for_b", 32'(rdy_b), 32'(SKID));
        step();
        if (rdy_b) in_valid = 1'b0;
        chk("bp_still_a",   out_data,       32'hA);
        chk("bp_cnt4",      32'(stall_cnt), 32'd4);
        chk("bp_rdy_low",   32'(in_ready),  32'd0);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        chk("bp_b_data",  out_data,       32'hB);
        chk("bp_rdy_back", 32'(in_ready), 32'd1);
        step();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // Flush beats a simultaneous input transfer
        in_valid  = 1'b1;
        in_ctrl   = 8'h33;
        in_data   = 32'h55;
        out_ready = 1'b0;
        step();
        chk("fl_load", out_data, 32'h55);
        flush     = 1'b1;
        in_ctrl   = 8'hFF;
        in_data   = 32'h77;
        out_ready = 1'b1;
        step();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ctrl",  32'(out_ctrl),  32'd0);
        chk("fl_data",  out_data,       32'h55);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl_dropped", 32'(out_valid), 32'd0);
        chk("fl_cnt_kept", 32'(stall_cnt), 32'd4);

        // Saturation and clear
        in_valid  = 1'b1;
        in_ctrl   = 8'h01;
        in_data   = 32'h99;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("sat_cnt",  32'(stall_cnt), 32'd15);
        chk("sat_data", out_data,       32'h99);
        stall_clr = 1'b1;
        step();
        chk("clr_cnt", 32'(stall_cnt), 32'd0);
        stall_clr = 1'b0;
        step();
        step();
        chk("resume_cnt", 32'(stall_cnt), 32'd2);

        // Asynchronous reset while a word is held
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ctrl",  32'(out_ctrl),  32'd0);
        chk("arst_cnt",   32'(stall_cnt), 32'd0);
        nRST = 1'b1;
        step();
        chk("arst_rdy", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
